ddr_rd_master: RTL and testbench

AXI4 read master that executes the single-burst read commands issued by the DDR bandwidth-test controller. It latches a start address and beat count on a one-cycle start strobe and issues one INCR burst on the AR channel. It then drains the R channel at full rate and reports completion through an idle flag. It sits between the controller and the Zynq HP/DDR port, and also keeps a running beat count and sticky error flags for software.

---
 rtl/ddr_bw_pkg.sv | 29 ++
 rtl/rd_pattern_chk.sv | 43 ++++
 rtl/ddr_rd_master.sv | 158 +++++++++++++++
 tb/tb_ddr_rd_master.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_bw_pkg.sv
// Shared types and constants for the DDR bandwidth-test read path.
package ddr_bw_pkg;

    typedef enum logic [1:0] {
        IDLE_ST = 2'd0,
        ADDR_ST = 2'd1,
        DATA_ST = 2'd2
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [3:0] AR_CACHE   = 4'b0011;

    localparam int unsigned ERR_W        = 4;
    localparam int unsigned ERR_4K_BIT   = 0;
    localparam int unsigned ERR_LAST_BIT = 1;
    localparam int unsigned ERR_RESP_BIT = 2;
    localparam int unsigned ERR_BUSY_BIT = 3;

    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned BEAT_BYTES = 8;

    // Requests longer than the largest supported burst are clamped.
    function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] max_beats);
        return (len > max_beats) ? max_beats : len;
    endfunction

endpackage

// File: rtl/rd_pattern_chk.sv
// Compares each accepted R beat with its own byte address and counts mismatches (saturating).
module rd_pattern_chk #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              load,
    input  logic [31:0]       base_addr,
    input  logic              beat,
    input  logic [DATA_W-1:0] rdata,
    output logic [31:0]       mismatch_cnt
);
    import ddr_bw_pkg::*;

    logic [31:0]       exp_addr;
    logic [DATA_W-1:0] exp_data_c;
    logic              miss_c;

    always_comb begin
        exp_data_c = DATA_W'(exp_addr);
        miss_c     = beat && (rdata != exp_data_c);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            exp_addr     <= '0;
            mismatch_cnt <= '0;
        end else begin
            if (load) begin
                exp_addr <= base_addr;
            end else if (beat) begin
                exp_addr <= exp_addr + 32'(BEAT_BYTES);
            end
            if (clr) begin
                mismatch_cnt <= '0;
            end else if (miss_c && (mismatch_cnt != 32'hFFFF_FFFF)) begin
                mismatch_cnt <= mismatch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/ddr_rd_master.sv
// Single-burst AXI4 read master for the DDR bandwidth test.
// Optional data checking is enabled by defining DDR_RD_CHECK_EN.
module ddr_rd_master #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              RSTART_REG,
    input  logic [31:0]       RADDR_REG,
    input  logic [31:0]       RLENGTH_REG,
    output logic              RIDLE_REG,
    input  logic              CLR_REG,
    output logic [31:0]       BEAT_CNT_REG,
    output logic [3:0]        ERR_REG,
    output logic [31:0]       MISMATCH_REG,
    output logic [31:0]       m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [5:0]        m_axi_arid,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);
    import ddr_bw_pkg::*;

    state_t      state;
    logic [31:0] n_q;
    logic [31:0] cnt_q;

    logic [31:0] n_c;
    logic [31:0] addr_c;
    logic [31:0] page_end_c;
    logic [31:0] cnt_next_c;
    logic        cross_c;
    logic        beat_c;
    logic        accept_c;

    assign m_axi_arsize  = SIZE_8B;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arid    = 6'd0;
    assign m_axi_arcache = AR_CACHE;
    assign m_axi_arprot  = 3'b000;

    // Request decode: clamp, beat-align, and check the end of the burst against the 4 KB page.
    always_comb begin
        n_c        = clamp_len(RLENGTH_REG, 32'(MAX_BEATS));
        addr_c     = {RADDR_REG[31:3], 3'b000};
        page_end_c = {20'd0, addr_c[11:0]} + (n_c << 3);
        cross_c    = page_end_c > 32'(PAGE_BYTES);
        beat_c     = (state == DATA_ST) && m_axi_rready && m_axi_rvalid;
        accept_c   = (state == IDLE_ST) && RSTART_REG && (n_c != 32'd0) && !cross_c;
        cnt_next_c = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE_ST;
            RIDLE_REG     <= 1'b1;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            n_q           <= '0;
            cnt_q         <= '0;
            BEAT_CNT_REG  <= '0;
            ERR_REG       <= '0;
        end else begin
            case (state)
                IDLE_ST: begin
                    if (accept_c) begin
                        state         <= ADDR_ST;
                        RIDLE_REG     <= 1'b0;
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= addr_c;
                        m_axi_arlen   <= 8'(n_c - 32'd1);
                        n_q           <= n_c;
                    end
                end
                ADDR_ST: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        state         <= DATA_ST;
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        cnt_q         <= '0;
                    end
                end
                DATA_ST: begin
                    if (beat_c) begin
                        cnt_q <= cnt_next_c;
                        if (m_axi_rlast) begin
                            state        <= IDLE_ST;
                            m_axi_rready <= 1'b0;
                            RIDLE_REG    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE_ST;
                end
            endcase

            // Software-visible counters; clear wins over any same-cycle update.
            if (CLR_REG) begin
                BEAT_CNT_REG <= '0;
                ERR_REG      <= '0;
            end else begin
                if (beat_c) begin
                    BEAT_CNT_REG <= BEAT_CNT_REG + 32'd1;
                end
                if ((state == IDLE_ST) && RSTART_REG && (n_c != 32'd0) && cross_c) begin
                    ERR_REG[ERR_4K_BIT] <= 1'b1;
                end
                if (beat_c && (m_axi_rresp != RESP_OKAY)) begin
                    ERR_REG[ERR_RESP_BIT] <= 1'b1;
                end
                if (beat_c && m_axi_rlast && (cnt_next_c != n_q)) begin
                    ERR_REG[ERR_LAST_BIT] <= 1'b1;
                end
                if (beat_c && !m_axi_rlast && (cnt_next_c >= n_q)) begin
                    ERR_REG[ERR_LAST_BIT] <= 1'b1;
                end
                if (RSTART_REG && (state != IDLE_ST)) begin
                    ERR_REG[ERR_BUSY_BIT] <= 1'b1;
                end
            end
        end
    end

`ifdef DDR_RD_CHECK_EN
    rd_pattern_chk #(
        .DATA_W(DATA_W)
    ) u_chk (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (CLR_REG),
        .load         (accept_c),
        .base_addr    (addr_c),
        .beat         (beat_c),
        .rdata        (m_axi_rdata),
        .mismatch_cnt (MISMATCH_REG)
    );
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^RADDR_REG[2:0];
`else
    assign MISMATCH_REG = '0;
    logic unused_rdata;
    assign unused_rdata = ^{m_axi_rdata, RADDR_REG[2:0]};
`endif

endmodule

// File: tb/tb_ddr_rd_master.sv
// Directed bench for ddr_rd_master: vector table plus hand-written corner sequences.
module tb_ddr_rd_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        RSTART_REG;
    logic [31:0] RADDR_REG;
    logic [31:0] RLENGTH_REG;
    logic        RIDLE_REG;
    logic        CLR_REG;
    logic [31:0] BEAT_CNT_REG;
    logic [3:0]  ERR_REG;
    logic [31:0] MISMATCH_REG;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [5:0]  m_axi_arid;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddr_rd_master #(.DATA_W(64), .MAX_BEATS(16)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .RSTART_REG    (RSTART_REG),
        .RADDR_REG     (RADDR_REG),
        .RLENGTH_REG   (RLENGTH_REG),
        .RIDLE_REG     (RIDLE_REG),
        .CLR_REG       (CLR_REG),
        .BEAT_CNT_REG  (BEAT_CNT_REG),
        .ERR_REG       (ERR_REG),
        .MISMATCH_REG  (MISMATCH_REG),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arid    (m_axi_arid),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        int          ar_wait;
        bit          throttle;
        bit          exp_issue;
        logic [31:0] exp_araddr;
        logic [7:0]  exp_arlen;
        int          exp_beats;
        logic [3:0]  exp_err;
        logic [31:0] exp_bcnt;
        int          exp_idle;
    } vec_t;

    vec_t vecs [5];

    bit          issued;
    bit          stable;
    logic [31:0] sa;
    logic [7:0]  sl;
    int          nb;
    int          idl;
    logic [31:0] exp_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Issues one start strobe and plays the slave side; reports what the master did.
    task automatic do_burst(input logic [31:0] addr, input logic [31:0] len, input int ar_wait,
                            input bit throttle, input int send, input int last_idx,
                            input int slverr_idx, input int bad_idx,
                            output bit iss, output logic [31:0] s_addr, output logic [7:0] s_len,
                            output bit stable_ok, output int beats, output int idle_cyc);
        int  start_cyc;
        bit  tog;
        bit  acc;
        @(negedge clk);
        RADDR_REG   = addr;
        RLENGTH_REG = len;
        RSTART_REG  = 1'b1;
        start_cyc   = cyc;
        @(negedge clk);
        RSTART_REG = 1'b0;
        iss        = m_axi_arvalid && !RIDLE_REG;
        s_addr     = m_axi_araddr;
        s_len      = m_axi_arlen;
        stable_ok  = 1'b1;
        beats      = 0;
        idle_cyc   = 0;
        if (!iss) begin
            if (m_axi_arvalid || !RIDLE_REG) stable_ok = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (m_axi_arvalid || !RIDLE_REG) stable_ok = 1'b0;
            end
            return;
        end
        for (int w = 0; w < ar_wait; w++) begin
            @(negedge clk);
            if (!m_axi_arvalid || m_axi_araddr !== s_addr || m_axi_arlen !== s_len) stable_ok = 1'b0;
        end
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        if (m_axi_arvalid || !m_axi_rready) stable_ok = 1'b0;
        tog = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (beats < send) begin
                tog          = !tog;
                m_axi_rvalid = throttle ? tog : 1'b1;
                m_axi_rdata  = 64'({addr[31:3], 3'b000}) + 64'(8 * beats);
                if (beats == bad_idx) m_axi_rdata = m_axi_rdata ^ 64'h1;
                m_axi_rlast  = (beats == last_idx);
                m_axi_rresp  = (beats == slverr_idx) ? 2'b10 : 2'b00;
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
            end
            acc = m_axi_rvalid && m_axi_rready;
            @(negedge clk);
            if (acc) beats++;
            if (RIDLE_REG) begin
                idle_cyc = cyc - start_cyc;
                break;
            end
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; RSTART_REG = 1'b0; RADDR_REG = '0; RLENGTH_REG = '0; CLR_REG = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;

        //            addr           len  wait thr iss araddr         arlen beats err   bcnt idle
        vecs[0] = '{32'h1000_0008, 32'd8,  0, 1'b0, 1'b1, 32'h1000_0008, 8'd7,  8, 4'h0, 32'd8,  10};
        vecs[1] = '{32'h2000_0100, 32'd20, 5, 1'b1, 1'b1, 32'h2000_0100, 8'd15, 16, 4'h0, 32'd24, 0};
        vecs[2] = '{32'h0000_0F87, 32'd16, 0, 1'b0, 1'b1, 32'h0000_0F80, 8'd15, 16, 4'h0, 32'd40, 18};
        vecs[3] = '{32'h1000_0000, 32'd0,  0, 1'b0, 1'b0, 32'h0,         8'd0,  0, 4'h0, 32'd40, 0};
        vecs[4] = '{32'h0000_0FF8, 32'd2,  0, 1'b0, 1'b0, 32'h0,         8'd0,  0, 4'h1, 32'd40, 0};

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk("rst ridle",   32'(RIDLE_REG), 32'd1);
        chk("rst arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("rst rready",  32'(m_axi_rready), 32'd0);
        chk("rst araddr",  m_axi_araddr, 32'd0);
        chk("rst arlen",   32'(m_axi_arlen), 32'd0);
        chk("rst beat_cnt", BEAT_CNT_REG, 32'd0);
        chk("rst err",     32'(ERR_REG), 32'd0);
        chk("rst mis",     MISMATCH_REG, 32'd0);
        chk("ar consts",   {15'd0, m_axi_arsize, m_axi_arburst, m_axi_arid, m_axi_arcache, m_axi_arprot},
                           {15'd0, 3'b011, 2'b01, 6'd0, 4'b0011, 3'b000});

        for (int i = 0; i < 5; i++) begin
            do_burst(vecs[i].addr, vecs[i].len, vecs[i].ar_wait, vecs[i].throttle,
                     vecs[i].exp_beats, vecs[i].exp_beats - 1, -1, -1,
                     issued, sa, sl, stable, nb, idl);
            chk($sformatf("v%0d issued", i), 32'(issued), 32'(vecs[i].exp_issue));
            chk($sformatf("v%0d stable", i), 32'(stable), 32'd1);
            if (vecs[i].exp_issue) begin
                chk($sformatf("v%0d araddr", i), sa, vecs[i].exp_araddr);
                chk($sformatf("v%0d arlen", i), 32'(sl), 32'(vecs[i].exp_arlen));
                chk($sformatf("v%0d beats", i), 32'(nb), 32'(vecs[i].exp_beats));
            end
            if (vecs[i].exp_idle != 0)
                chk($sformatf("v%0d idle_cyc", i), 32'(idl), 32'(vecs[i].exp_idle));
            chk($sformatf("v%0d ridle", i), 32'(RIDLE_REG), 32'd1);
            chk($sformatf("v%0d rready", i), 32'(m_axi_rready), 32'd0);
            chk($sformatf("v%0d err", i), 32'(ERR_REG), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d beat_cnt", i), BEAT_CNT_REG, vecs[i].exp_bcnt);
        end
        chk("tbl mis", MISMATCH_REG, 32'd0);

        // Early rlast on beat 3 of 8, SLVERR on beat 2.
        do_burst(32'h4000_0000, 32'd8, 1, 1'b0, 3, 2, 1, -1, issued, sa, sl, stable, nb, idl);
        chk("slv issued", 32'(issued), 32'd1);
        chk("slv beats", 32'(nb), 32'd3);
        chk("slv ridle", 32'(RIDLE_REG), 32'd1);
        chk("slv rready", 32'(m_axi_rready), 32'd0);
        chk("slv err", 32'(ERR_REG), 32'b0111);
        chk("slv beat_cnt", BEAT_CNT_REG, 32'd43);

        // Start while busy, then clear, then reset mid-burst.
        @(negedge clk);
        RADDR_REG = 32'h5000_0000; RLENGTH_REG = 32'd4; RSTART_REG = 1'b1;
        @(negedge clk);
        RSTART_REG = 1'b0; m_axi_arready = 1'b1;
        chk("busy ridle0", 32'(RIDLE_REG), 32'd0);
        @(negedge clk);
        m_axi_arready = 1'b0;
        chk("busy rready", 32'(m_axi_rready), 32'd1);
        RSTART_REG = 1'b1; RADDR_REG = 32'h7000_0000;
        @(negedge clk);
        RSTART_REG = 1'b0;
        chk("busy err", 32'(ERR_REG), 32'b1111);
        chk("busy ridle", 32'(RIDLE_REG), 32'd0);
        chk("busy arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("busy araddr", m_axi_araddr, 32'h5000_0000);
        CLR_REG = 1'b1;
        @(negedge clk);
        CLR_REG = 1'b0;
        chk("clr beat_cnt", BEAT_CNT_REG, 32'd0);
        chk("clr err", 32'(ERR_REG), 32'd0);
        chk("clr mis", MISMATCH_REG, 32'd0);
        m_axi_rvalid = 1'b1; m_axi_rdata = 64'h5000_0000; m_axi_rlast = 1'b0;
        @(negedge clk);
        m_axi_rdata = 64'h5000_0008;
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        chk("mid beat_cnt", BEAT_CNT_REG, 32'd2);
        chk("mid ridle", 32'(RIDLE_REG), 32'd0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("mrst arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("mrst rready", 32'(m_axi_rready), 32'd0);
        chk("mrst ridle", 32'(RIDLE_REG), 32'd1);
        chk("mrst beat_cnt", BEAT_CNT_REG, 32'd0);
        chk("mrst err", 32'(ERR_REG), 32'd0);

        do_burst(32'h5000_0000, 32'd2, 0, 1'b0, 2, 1, -1, -1, issued, sa, sl, stable, nb, idl);
        chk("post beats", 32'(nb), 32'd2);
        chk("post idle_cyc", 32'(idl), 32'd4);
        chk("post err", 32'(ERR_REG), 32'd0);

        // Beat 4 carries corrupted data.
        do_burst(32'h6000_0040, 32'd8, 0, 1'b0, 8, 7, -1, 4, issued, sa, sl, stable, nb, idl);
`ifdef DDR_RD_CHECK_EN
        exp_mis = 32'd1;
`else
        exp_mis = 32'd0;
`endif
        chk("dchk beats", 32'(nb), 32'd8);
        chk("dchk beat_cnt", BEAT_CNT_REG, 32'd10);
        chk("dchk err", 32'(ERR_REG), 32'd0);
        chk("dchk mis", MISMATCH_REG, exp_mis);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
